// File: rtl/adapter_stream_pkg.sv
// Shared definitions for the eInstream/eOutstream stream adapters:
// pointer-width helper, parameter sanity checks and handshake-state encodings.
package adapter_stream_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StWaitAck
  } hs_state_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit pkt_len_ok(input int unsigned pkt_len);
    return pkt_len >= 1;
  endfunction

endpackage

// File: rtl/adapter_fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// Storage is deliberately not reset.
module adapter_fifo_ram
  import adapter_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adapter_e_outstream.sv
// ap_hs accelerator output port to AXI4-Stream master through an elastic FIFO.
// Optional framing (out_r_tlast every PKT_LEN beats) under ADAPTER_E_OUTSTREAM_TLAST_EN.
module adapter_e_outstream
  import adapter_stream_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PKT_LEN = 1
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [DATA_W-1:0]        in_V,
  input  logic                     in_V_ap_vld,
  output logic                     in_V_ap_ack,
  output logic                     out_r_tvalid,
  input  logic                     out_r_tready,
  output logic [DATA_W-1:0]        out_r_tdata,
  output logic [$clog2(DEPTH):0]   level
`ifdef ADAPTER_E_OUTSTREAM_TLAST_EN
  ,
  output logic                     out_r_tlast
`endif
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("adapter_e_outstream: DEPTH must be a power of two >= 2");
  end
  if (!pkt_len_ok(PKT_LEN)) begin : g_bad_pkt_len
    $error("adapter_e_outstream: PKT_LEN must be >= 1");
  end

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_en, rd_en;

  // Ack depends only on registered count so there is no vld->ack combinational path.
  assign in_V_ap_ack  = aresetn && (count_q != FullCnt);
  assign out_r_tvalid = (count_q != '0);
  assign level        = count_q;

  assign wr_en = in_V_ap_vld && in_V_ap_ack;
  assign rd_en = out_r_tvalid && out_r_tready;

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CntW'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  adapter_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (in_V),
    .raddr (rd_ptr_q),
    .rdata (out_r_tdata)
  );

`ifdef ADAPTER_E_OUTSTREAM_TLAST_EN
  localparam int unsigned BeatW = $clog2(PKT_LEN) + 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(PKT_LEN - 1);

  logic [BeatW-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (rd_en) begin
      beat_d = (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign out_r_tlast = out_r_tvalid && (beat_q == LastBeat);
`endif

endmodule

// File: tb/tb_adapter_e_outstream.sv
// Self-checking bench for adapter_e_outstream: vector table, hand sequences and a
// scoreboard monitor. Define ADAPTER_E_OUTSTREAM_TLAST_EN to exercise framing.
module tb_adapter_e_outstream;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
`ifdef ADAPTER_E_OUTSTREAM_TLAST_EN
  localparam int unsigned PKT_LEN = 3;
`else
  localparam int unsigned PKT_LEN = 1;
`endif

  logic              clk;
  logic              aresetn;
  logic [DATA_W-1:0] in_V;
  logic              in_V_ap_vld;
  logic              in_V_ap_ack;
  logic              out_r_tvalid;
  logic              out_r_tready;
  logic [DATA_W-1:0] out_r_tdata;
  logic [2:0]        level;
`ifdef ADAPTER_E_OUTSTREAM_TLAST_EN
  logic              out_r_tlast;
`endif

  adapter_e_outstream #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .PKT_LEN (PKT_LEN)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .in_V         (in_V),
    .in_V_ap_vld  (in_V_ap_vld),
    .in_V_ap_ack  (in_V_ap_ack),
    .out_r_tvalid (out_r_tvalid),
    .out_r_tready (out_r_tready),
    .out_r_tdata  (out_r_tdata),
    .level        (level)
`ifdef ADAPTER_E_OUTSTREAM_TLAST_EN
    ,
    .out_r_tlast  (out_r_tlast)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t        sb_q[$];
  int          n_push = 0;
  int          acc_cnt = 0;
  logic        have_prev = 1'b0;
  logic        prev_v, prev_r, prev_l;
  logic [DATA_W-1:0] prev_d;

  always @(negedge clk) begin
    exp_t e;
    logic cur_last;
`ifdef ADAPTER_E_OUTSTREAM_TLAST_EN
    cur_last = out_r_tlast;
`else
    cur_last = 1'b0;
`endif
    if (!aresetn) begin
      sb_q.delete();
      acc_cnt   = 0;
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_v && !prev_r) begin
        checks++;
        if (!out_r_tvalid || out_r_tdata !== prev_d || cur_last !== prev_l) begin
          errors++;
          $display("FAIL axis_stable: got v=%0b d=%0h l=%0b, expected v=1 d=%0h l=%0b",
                   out_r_tvalid, out_r_tdata, cur_last, prev_d, prev_l);
        end
      end
      if (level == 3'(DEPTH)) begin
        checks++;
        if (in_V_ap_ack !== 1'b0) begin
          errors++;
          $display("FAIL ack_when_full: got ack=%0b, expected 0", in_V_ap_ack);
        end
      end
      if (in_V_ap_vld && in_V_ap_ack) begin
        e.data = in_V;
        e.last = (acc_cnt == int'(PKT_LEN) - 1);
        acc_cnt = (acc_cnt == int'(PKT_LEN) - 1) ? 0 : acc_cnt + 1;
        sb_q.push_back(e);
        n_push++;
      end
      if (out_r_tvalid && out_r_tready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got beat %0h, expected none", out_r_tdata);
        end else begin
          e = sb_q.pop_front();
          if (out_r_tdata !== e.data) begin
            errors++;
            $display("FAIL sb_data: got %0h, expected %0h", out_r_tdata, e.data);
          end
`ifdef ADAPTER_E_OUTSTREAM_TLAST_EN
          checks++;
          if (out_r_tlast !== e.last) begin
            errors++;
            $display("FAIL sb_tlast: data %0h got tlast=%0b, expected %0b",
                     out_r_tdata, out_r_tlast, e.last);
          end
`endif
        end
      end
      have_prev = 1'b1;
      prev_v = out_r_tvalid;
      prev_r = out_r_tready;
      prev_d = out_r_tdata;
      prev_l = cur_last;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              ack;
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic [2:0]        lvl;
  } vec_t;

  vec_t vec[16];

  task automatic apply_vec(input int i);
    @(posedge clk); #1;
    in_V_ap_vld  = vec[i].vld;
    in_V         = vec[i].data;
    out_r_tready = vec[i].ready;
    @(negedge clk);
    check($sformatf("vec%0d_ack", i), 32'(in_V_ap_ack), 32'(vec[i].ack));
    check($sformatf("vec%0d_tvalid", i), 32'(out_r_tvalid), 32'(vec[i].tvalid));
    check($sformatf("vec%0d_level", i), 32'(level), 32'(vec[i].lvl));
    if (vec[i].tvalid) check($sformatf("vec%0d_tdata", i), 32'(out_r_tdata), 32'(vec[i].tdata));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    aresetn = 1'b0;
    in_V_ap_vld = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    aresetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int start;
    int k;

    vec[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1};
    vec[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vec[3]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    vec[4]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 3'd1};
    vec[5]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2};
    vec[6]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3};
    vec[7]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
    vec[8]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
    vec[9]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'h01, 3'd4};
    vec[10] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02, 3'd3};
    vec[11] = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h03, 3'd3};
    vec[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 3'd3};
    vec[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 3'd2};
    vec[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h06, 3'd1};
    vec[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};

    aresetn = 1'b0;
    in_V = '0;
    in_V_ap_vld = 1'b0;
    out_r_tready = 1'b0;

    // Reset state
    #3;
    check("rst_ack", 32'(in_V_ap_ack), 32'd0);
    check("rst_tvalid", 32'(out_r_tvalid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    check("post_rst_ack", 32'(in_V_ap_ack), 32'd1);
    check("post_rst_tvalid", 32'(out_r_tvalid), 32'd0);

    // Single beat and back-pressure fill
    for (int i = 0; i <= 8; i++) apply_vec(i);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_tvalid", 32'(out_r_tvalid), 32'd1);
      check("hold_tdata", 32'(out_r_tdata), 32'h01);
      check("hold_ack", 32'(in_V_ap_ack), 32'd0);
    end
    for (int i = 9; i <= 15; i++) apply_vec(i);

    // Reset mid-transfer with two words buffered
    @(posedge clk); #1;
    out_r_tready = 1'b0; in_V_ap_vld = 1'b1; in_V = 8'h77;
    @(posedge clk); #1;
    in_V = 8'h78;
    @(posedge clk); #1;
    in_V_ap_vld = 1'b1; in_V = 8'h79;
    check("pre_rst_level", 32'(level), 32'd2);
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", 32'(out_r_tvalid), 32'd0);
    check("midrst_ack", 32'(in_V_ap_ack), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    in_V_ap_vld = 1'b0;
    aresetn = 1'b1;
    @(negedge clk);
    check("rel_ack", 32'(in_V_ap_ack), 32'd1);
    check("rel_tvalid", 32'(out_r_tvalid), 32'd0);
    check("rel_level", 32'(level), 32'd0);

    // Streaming: one beat per cycle, level pinned at 1
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      in_V_ap_vld = 1'b1; in_V = 8'(8'h40 + i); out_r_tready = 1'b1;
      @(negedge clk);
      check("stream_level", 32'(level), (i == 0) ? 32'd0 : 32'd1);
      check("stream_tvalid", 32'(out_r_tvalid), (i == 0) ? 32'd0 : 32'd1);
    end
    @(posedge clk); #1;
    in_V_ap_vld = 1'b0;
    @(negedge clk);
    check("stream_tail_level", 32'(level), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stream_drained", 32'(level), 32'd0);
    check("stream_sb_empty", 32'(sb_q.size()), 32'd0);

    // Random vld/tready, 1000 accepted beats
    start = n_push;
    cyc = 0;
    while ((n_push - start) < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      in_V_ap_vld  = 1'($urandom_range(0, 1));
      in_V         = 8'($urandom);
      out_r_tready = 1'($urandom_range(0, 1));
      cyc++;
    end
    check("rand_pushed", 32'(n_push - start >= 1000), 32'd1);
    @(posedge clk); #1;
    in_V_ap_vld = 1'b0; out_r_tready = 1'b1;
    cyc = 0;
    while (level != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    check("rand_drained", 32'(level), 32'd0);
    check("rand_sb_empty", 32'(sb_q.size()), 32'd0);

`ifdef ADAPTER_E_OUTSTREAM_TLAST_EN
    // Framing: 0x10..0x18 with random back-pressure
    do_reset();
    k = 0;
    cyc = 0;
    while ((k < 9 || level != 0) && cyc < 300) begin
      @(posedge clk); #1;
      in_V_ap_vld  = (k < 9);
      in_V         = 8'(8'h10 + k);
      out_r_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_V_ap_vld && in_V_ap_ack) k++;
      cyc++;
    end
    check("tlast_done", 32'(k == 9 && level == 0), 32'd1);
    check("tlast_sb_empty", 32'(sb_q.size()), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
